// File: rtl/spi_xfer_ctrl_if.sv
// Byte-level handshake, clock-generator control and SPI pin bundle for spi_xfer_ctrl.
// master: the transaction controller; slave: polling logic, clock generator and pins.
interface spi_xfer_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              done;
  logic              r_edge;
  logic              f_edge;
  logic              en_oclk;
  logic              idle_v;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, len, tx_data, r_edge, f_edge, miso,
    output tx_ack, rx_data, rx_valid, busy, done, en_oclk, idle_v, cs_n, mosi
  );

  modport slave (
    output start, len, tx_data, r_edge, f_edge, miso,
    input  tx_ack, rx_data, rx_valid, busy, done, en_oclk, idle_v, cs_n, mosi
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI transaction sequencer: chip select, MSB-first shift out/in and word counting,
// driven by the single-cycle leading/trailing strobes of the SPI clock generator.
module spi_xfer_ctrl #(
  parameter int unsigned SPI_MODE = 0,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned CS_DLY   = 2
) (
  input logic             clk,
  input logic             rst,
  spi_xfer_ctrl_if.master bus
);

  localparam bit          CPOL = ((SPI_MODE / 2) % 2) == 1;
  localparam bit          CPHA = (SPI_MODE % 2) == 1;
  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned DlyW = $clog2(CS_DLY + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StDone} state_e;

  state_e            state_q, state_d;
  logic [DlyW-1:0]   dly_q, dly_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [LEN_W-1:0]  word_q, word_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_ack_q, tx_ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;
  logic              en_q, en_d;
  logic              mosi_q, mosi_d;
  logic              last_q, last_d;

  logic              sample_ev, shift_ev;
  logic [DATA_W-1:0] tx_shift, rx_next;

  assign sample_ev = CPHA ? bus.f_edge : bus.r_edge;
  assign shift_ev  = CPHA ? bus.r_edge : bus.f_edge;
  assign tx_shift  = tx_sr_q << 1;
  assign rx_next   = (rx_sr_q << 1) | DATA_W'(bus.miso);

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    bit_d      = bit_q;
    word_d     = word_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ack_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cs_n_d     = cs_n_q;
    en_d       = en_q;
    mosi_d     = mosi_q;
    last_d     = last_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            word_d  = bus.len;
            bit_d   = '0;
            dly_d   = '0;
            last_d  = 1'b0;
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = StSetup;
            // CPHA=1 loads the first word on its first leading strobe instead
            if (!CPHA) begin
              tx_ack_d = 1'b1;
              tx_sr_d  = bus.tx_data;
              mosi_d   = bus.tx_data[DATA_W-1];
            end
          end else begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end

      StSetup: begin
        if (dly_q == DlyW'(CS_DLY - 1)) begin
          en_d    = 1'b1;
          state_d = StXfer;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      StXfer: begin
        if (sample_ev && !last_q) begin
          rx_sr_d = rx_next;
          if (bit_q == BitW'(DATA_W - 1)) begin
            bit_d      = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            word_d     = word_q - 1'b1;
            if (word_q == LEN_W'(1)) begin
              if (CPHA) begin
                en_d    = 1'b0;
                dly_d   = '0;
                state_d = StHold;
              end else begin
                last_d = 1'b1;
              end
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else if (shift_ev) begin
          if (last_q) begin
            en_d    = 1'b0;
            dly_d   = '0;
            state_d = StHold;
          end else if (bit_q == '0) begin
            // Word boundary: CPHA=0 after a completed word, CPHA=1 before the first bit
            tx_ack_d = 1'b1;
            tx_sr_d  = bus.tx_data;
            mosi_d   = bus.tx_data[DATA_W-1];
          end else begin
            tx_sr_d = tx_shift;
            mosi_d  = tx_shift[DATA_W-1];
          end
        end
      end

      StHold: begin
        if (dly_q == DlyW'(CS_DLY - 1)) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      dly_q      <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      en_q       <= 1'b0;
      mosi_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ack_q   <= tx_ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      en_q       <= en_d;
      mosi_q     <= mosi_d;
      last_q     <= last_d;
    end
  end

  assign bus.tx_ack   = tx_ack_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.en_oclk  = en_q;
  assign bus.idle_v   = CPOL;
  assign bus.cs_n     = cs_n_q;
  assign bus.mosi     = mosi_q;

endmodule
